// File: rtl/pipeline_skid_stage_pkg.sv
// Shared definitions for the pipeline skid stage: state encoding, default widths
// and the state-to-occupancy decode.
package pipeline_skid_stage_pkg;

  localparam int DEFAULT_DATA_WIDTH      = 32;
  localparam int DEFAULT_STALL_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  // Number of beats held in a given state.
  function automatic logic [1:0] occupancy_of(input skid_state_t st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipeline_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_r;

  // Count up on inc until the all-ones ceiling is reached.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != COUNT_MAX)) begin
      count_r <= count_r + WIDTH'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_skid_stage.sv
// Two-entry skid buffer between valid/ready interfaces. in_ready is a register
// so upstream never sees a combinational path from out_ready.
module pipeline_skid_stage
  import pipeline_skid_stage_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int STALL_CNT_WIDTH = DEFAULT_STALL_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
  output logic [1:0]                 occupancy,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  skid_state_t           state_r;
  skid_state_t           state_nxt_s;
  logic [DATA_WIDTH-1:0] main_r;
  logic [DATA_WIDTH-1:0] skid_r;
  logic [DATA_WIDTH-1:0] main_nxt_s;
  logic [DATA_WIDTH-1:0] skid_nxt_s;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [1:0]            occupancy_r;
  logic                  stall_inc_s;

  // Next-state and payload steering; flush empties the stage regardless of handshakes.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_valid) begin
            main_nxt_s  = in_data;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            main_nxt_s  = in_data;
            state_nxt_s = ST_ONE;
          end else if (in_valid) begin
            // Downstream stalled while upstream still had ready=1: park the beat.
            skid_nxt_s  = in_data;
            state_nxt_s = ST_FULL;
          end else if (out_ready) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            main_nxt_s  = skid_r;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State, payload and registered handshake outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      main_r      <= {DATA_WIDTH{1'b0}};
      skid_r      <= {DATA_WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_FULL);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      occupancy_r <= occupancy_of(state_nxt_s);
    end
  end

  assign stall_inc_s = out_valid_r && !out_ready;

  sat_counter #(
    .WIDTH (STALL_CNT_WIDTH)
  ) u_stall_counter (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc_s),
    .count (stall_count)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occupancy_r;

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Directed vector table plus hand-written corner sequences and a random
// valid/ready scoreboard for pipeline_skid_stage.
module tb_pipeline_skid_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        in_ready,   in_ready_sat;
  logic        out_valid,  out_valid_sat;
  logic [31:0] out_data,   out_data_sat;
  logic [1:0]  occupancy,  occupancy_sat;
  logic [15:0] stall_count;
  logic [2:0]  stall_count_sat;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        flush;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic        chk_d;
    logic [31:0] e_d;
    logic [1:0]  e_occ;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] sb[$];

  pipeline_skid_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .stall_count(stall_count)
  );

  pipeline_skid_stage #(.DATA_WIDTH(32), .STALL_CNT_WIDTH(3)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_sat), .out_valid(out_valid_sat), .out_data(out_data_sat),
    .out_ready(out_ready), .occupancy(occupancy_sat), .stall_count(stall_count_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] id,
                              input logic ordy, input logic e_irdy, input logic e_ov,
                              input logic chk_d, input logic [31:0] e_d,
                              input logic [1:0] e_occ, input logic [15:0] e_stall);
    vec_t v;
    v.flush = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.chk_d = chk_d; v.e_d = e_d;
    v.e_occ = e_occ; v.e_stall = e_stall;
    return v;
  endfunction

  initial begin
    logic ir_a, ir_b, iv_r, ordy_r, in_fire, out_fire;
    logic [31:0] d_r, exp_d;

    // Streaming: beat k appears on out_data one cycle after it is presented.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1'b0, 1'b1, 32'(k), 1'b1, 1'b1, 1'b1, 1'b1, 32'(k), 2'd1, 16'd0));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 16'd0));
    // Backpressure: 0xA, 0xB pile up, two held cycles, then drain in order.
    vecs.push_back(mk(1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA, 2'd1, 16'd0));
    vecs.push_back(mk(1'b0, 1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 2'd2, 16'd1));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 2'd2, 16'd2));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hB, 2'd1, 16'd2));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 16'd2));
    // Flush in FULL with a beat 0xC offered: nothing survives, 0xC never shows.
    vecs.push_back(mk(1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 2'd1, 16'd2));
    vecs.push_back(mk(1'b0, 1'b1, 32'h12, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 2'd2, 16'd3));
    vecs.push_back(mk(1'b1, 1'b1, 32'hC,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 16'd3));
    vecs.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 16'd3));
    vecs.push_back(mk(1'b0, 1'b1, 32'h21, 1'b1, 1'b1, 1'b1, 1'b1, 32'h21, 2'd1, 16'd3));

    // Reset state
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flush, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      step();
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_irdy));
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("v%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].e_occ));
      chk($sformatf("v%0d_stall", i), 64'(stall_count), 64'(vecs[i].e_stall));
      if (vecs[i].chk_d)
        chk($sformatf("v%0d_out_data", i), 64'(out_data), 64'(vecs[i].e_d));
    end

    // Saturation: one held beat, 12 stalled cycles; narrow counter stops at 7.
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h5, 1'b0);
    step();
    chk("sat_start", 64'(stall_count_sat), 64'd0);
    for (int k = 1; k <= 12; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      step();
      chk($sformatf("sat_narrow_%0d", k), 64'(stall_count_sat), 64'((k > 7) ? 7 : k));
    end
    chk("sat_wide", 64'(stall_count), 64'd12);

    // Reset mid-operation from FULL, then 0xD accepted straight away.
    drive(1'b0, 1'b1, 32'h31, 1'b0);
    step();
    drive(1'b0, 1'b1, 32'h32, 1'b0);
    step();
    chk("mid_full_occ", 64'(occupancy), 64'd2);
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'h33, 1'b1);
    step();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_stall", 64'(stall_count), 64'd0);
    chk("mid_rst_occ", 64'(occupancy), 64'd0);
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'hD, 1'b0);
    step();
    chk("post_rst_out_valid", 64'(out_valid), 64'd1);
    chk("post_rst_out_data", 64'(out_data), 64'hD);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    chk("post_rst_drain", 64'(occupancy), 64'd0);

    // Random valid/ready against a FIFO scoreboard.
    for (int c = 0; c < 10000; c++) begin
      iv_r   = ($urandom_range(0, 3) != 0);
      ordy_r = 1'($urandom_range(0, 1));
      d_r    = $urandom;
      drive(1'b0, iv_r, d_r, ordy_r);
      ir_a = in_ready;
      out_ready = ~ordy_r;
      #1;
      ir_b = in_ready;
      out_ready = ordy_r;
      chk("rand_in_ready_indep", 64'(ir_b), 64'(ir_a));
      chk("rand_occupancy", 64'(occupancy), 64'(sb.size()));
      in_fire  = iv_r && in_ready;
      out_fire = out_valid && ordy_r;
      if (out_fire) begin
        if (sb.size() == 0) begin
          chk("rand_unexpected_beat", 64'(out_data), 64'hFFFF_FFFF_0000_0000);
        end else begin
          exp_d = sb.pop_front();
          chk("rand_out_data", 64'(out_data), 64'(exp_d));
        end
      end
      if (in_fire) sb.push_back(d_r);
      step();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("drain_unexpected_beat", 64'(out_data), 64'hFFFF_FFFF_0000_0000);
        end else begin
          exp_d = sb.pop_front();
          chk("drain_out_data", 64'(out_data), 64'(exp_d));
        end
      end
      step();
    end
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_occupancy", 64'(occupancy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_stage.md
PIPELINE_SKID_STAGE -- requirements
Module: pipeline_skid_stage

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, giving the payload width in bits (legal range 1..128).
REQ-002 The block SHALL take parameter STALL_CNT_WIDTH, default 16, giving the stall counter width in bits (legal range 1..32).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit: discard all held beats.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream beat is present.
REQ-007 The block SHALL have port in_data, input, DATA_WIDTH bits: the upstream payload.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the stage accepts a beat this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the downstream beat is present.
REQ-010 The block SHALL have port out_data, output, DATA_WIDTH bits: the downstream payload.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-012 The block SHALL have port occupancy, output, 2 bits: the number of held beats (0..2).
REQ-013 The block SHALL have port stall_count, output, STALL_CNT_WIDTH bits: the number of backpressured cycles.

Function
REQ-014 A transfer SHALL occur on a rising edge where valid and ready are both 1 on that side.
REQ-015 The state machine SHALL have three states: EMPTY (occupancy 0), ONE (main register valid), FULL (main and skid registers valid).
REQ-016 in_ready SHALL be driven from a register, equal to 1 in EMPTY and ONE and 0 in FULL, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 in ONE and FULL, and out_data SHALL always come from the main register.
REQ-018 In EMPTY, in_valid=1 SHALL load the main register and move the machine to ONE.
REQ-019 In ONE with in_valid=1 and out_ready=1, the main register SHALL be replaced by in_data and the machine SHALL stay in ONE.
REQ-020 In ONE with in_valid=1 and out_ready=0, in_data SHALL be captured into the skid register and the machine SHALL move to FULL.
REQ-021 In ONE with in_valid=0 and out_ready=1, the machine SHALL move to EMPTY.
REQ-022 In FULL with out_ready=1, the main register SHALL take the skid register value and the machine SHALL move to ONE, with in_valid ignored because in_ready=0.
REQ-023 Beats SHALL be delivered in order, with none lost or duplicated, and the latency from in-transfer to out_valid SHALL be 1 cycle when empty.
REQ-024 With in_valid and out_ready held at 1 continuously, the stage SHALL sustain one beat per cycle.
REQ-025 Flush=1 SHALL move the machine to EMPTY on the next edge and SHALL override all other inputs.
REQ-026 A beat presented in the flush cycle SHALL be dropped, and a downstream handshake in that cycle SHALL still count as delivered.
REQ-027 stall_count SHALL increment by 1 in every cycle with out_valid=1 and out_ready=0.
REQ-028 stall_count SHALL saturate at 2^STALL_CNT_WIDTH-1 and SHALL NOT wrap.
REQ-029 stall_count SHALL be unaffected by flush.
REQ-030 Payload registers SHALL retain their stale contents when invalid, and out_data SHALL be don't-care while out_valid=0.

Reset
REQ-031 Reset=1 SHALL, on the next edge, force EMPTY, occupancy=0, out_valid=0, in_ready=1, out_data=0, and stall_count=0.
REQ-032 Reset SHALL take priority over flush and over all handshakes.
REQ-033 Reset asserted mid-operation SHALL discard all held beats.
REQ-034 The first transfer after reset SHALL be accepted in the first cycle in which reset=0.

Structure
REQ-035 The state encoding (EMPTY/ONE/FULL) SHALL be placed in the shared pipeline package as a 2-bit type with named constants.
REQ-036 The default widths SHALL be placed in the shared pipeline package with the state encoding.
REQ-037 The saturating counter SHALL be implemented as the single sub-module sat_counter, parameterised by width, with inputs inc and clear.
REQ-038 The rest of the block SHALL remain a single flat module.

Verification
REQ-039 The bench SHALL cover streaming: 8 beats 0x1..0x8 with out_ready=1 throughout shall produce out_data 0x1..0x8 on 8 consecutive cycles, starting one cycle after the first input, with stall_count=0.
REQ-040 The bench SHALL cover backpressure: with out_ready=0 and beats 0xA, 0xB sent, it shall reach FULL, in_ready=0, and occupancy=2; after out_ready=1, out_data shall be 0xA then 0xB, and stall_count shall equal the number of held cycles.
REQ-041 The bench SHALL cover flush: flush in FULL together with in_valid=1 and data 0xC shall give occupancy=0 on the next cycle, 0xC never appearing on the output, and stall_count unchanged.
REQ-042 The bench SHALL cover saturation: with STALL_CNT_WIDTH=3 and out_ready=0 for 12 cycles, stall_count shall stop at 7.
REQ-043 The bench SHALL cover reset mid-operation: reset in FULL shall give out_valid=0, in_ready=1, out_data=0, and stall_count=0 on the next cycle, after which 0xD shall be accepted immediately.
REQ-044 The bench SHALL cover random valid/ready with a scoreboard over 10k cycles, showing in-order delivery with no loss or duplication, and showing in_ready never depending combinationally on out_ready.
